// File: rtl/regfile_2r1w_sb.sv
// Parametrised register file: one write port, two registered read ports with
// write-to-read bypass, synchronous bulk clear and a per-register busy scoreboard.
module regfile_2r1w_sb #(
  parameter int              WIDTH     = 16,
  parameter int              DEPTH     = 8,
  parameter int              AW        = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             write,
  input  logic [AW-1:0]    writenum,
  input  logic [WIDTH-1:0] data_in,
  input  logic             reserve,
  input  logic [AW-1:0]    reservenum,
  input  logic             rd_en_a,
  input  logic [AW-1:0]    readnum_a,
  output logic [WIDTH-1:0] data_out_a,
  output logic             hazard_a,
  input  logic             rd_en_b,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_b,
  output logic             hazard_b,
  output logic [DEPTH-1:0] busy
);

  // Widened depth so a select can be range-checked even when DEPTH is not a power of two.
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] r_busy;
  logic [WIDTH-1:0] r_data_a;
  logic [WIDTH-1:0] r_data_b;
  logic             r_haz_a;
  logic             r_haz_b;

  logic w_wr_ok;
  logic w_rs_ok;
  logic w_rd_ok_a;
  logic w_rd_ok_b;
  logic w_byp_a;
  logic w_byp_b;

  always_comb begin
    w_wr_ok   = write && !clear && ({1'b0, writenum} < DEPTH_W);
    w_rs_ok   = reserve && !clear && ({1'b0, reservenum} < DEPTH_W);
    w_rd_ok_a = ({1'b0, readnum_a} < DEPTH_W);
    w_rd_ok_b = ({1'b0, readnum_b} < DEPTH_W);
    w_byp_a   = write && !clear && (writenum == readnum_a);
    w_byp_b   = write && !clear && (writenum == readnum_b);
  end

  // Storage and scoreboard. Reserve is applied after write so a same-edge
  // reserve of the written register leaves it busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
      r_busy <= '0;
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VAL;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) begin
        r_mem[writenum]  <= data_in;
        r_busy[writenum] <= 1'b0;
      end
      if (w_rs_ok) r_busy[reservenum] <= 1'b1;
    end
  end

  // Read port A. Clear suppresses bypass, so reads see pre-clear contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_a <= '0;
      r_haz_a  <= 1'b0;
    end else if (rd_en_a) begin
      if (!w_rd_ok_a) begin
        r_data_a <= '0;
        r_haz_a  <= 1'b0;
      end else if (w_byp_a) begin
        r_data_a <= data_in;
        r_haz_a  <= 1'b0;
      end else begin
        r_data_a <= r_mem[readnum_a];
        r_haz_a  <= r_busy[readnum_a];
      end
    end else begin
      r_haz_a <= 1'b0;
    end
  end

  // Read port B, identical to port A.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data_b <= '0;
      r_haz_b  <= 1'b0;
    end else if (rd_en_b) begin
      if (!w_rd_ok_b) begin
        r_data_b <= '0;
        r_haz_b  <= 1'b0;
      end else if (w_byp_b) begin
        r_data_b <= data_in;
        r_haz_b  <= 1'b0;
      end else begin
        r_data_b <= r_mem[readnum_b];
        r_haz_b  <= r_busy[readnum_b];
      end
    end else begin
      r_haz_b <= 1'b0;
    end
  end

  assign data_out_a = r_data_a;
  assign hazard_a   = r_haz_a;
  assign data_out_b = r_data_b;
  assign hazard_b   = r_haz_b;
  assign busy       = r_busy;

endmodule

// File: doc/regfile_2r1w_sb.md
Name: regfile_2r1w_sb

Overview:
- Parametrised successor to the 8x16 single-read-port register file for the datapath.
- Provides one write port and two independent registered read ports (A, B), one for each ALU operand.
- Adds write-to-read bypass, synchronous bulk clear, and a per-register busy scoreboard that the controller FSM uses to detect read-after-reserve hazards.

Parameters:
- WIDTH, 16, data width in bits of each register.
- DEPTH, 8, number of registers. Must be at least 2.
- AW, 3, register-select width. Must equal clog2(DEPTH).
- RESET_VAL, 0, value loaded into every register on reset or clear. WIDTH bits.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous clear of all registers and busy bits.
- write  in  1  write enable.
- writenum  in  AW  register to write.
- data_in  in  WIDTH  write data.
- reserve  in  1  set the busy bit of reservenum.
- reservenum  in  AW  register to reserve.
- rd_en_a  in  1  read enable, port A.
- readnum_a  in  AW  register to read, port A.
- data_out_a  out  WIDTH  registered read data, port A.
- hazard_a  out  1  port A read a busy register.
- rd_en_b  in  1  read enable, port B.
- readnum_b  in  AW  register to read, port B.
- data_out_b  out  WIDTH  registered read data, port B.
- hazard_b  out  1  port B read a busy register.
- busy  out  DEPTH  scoreboard; bit i is 1 while register i is reserved.

Behaviour:
- Reset: rst_n low asynchronously forces the following, and they hold while rst_n is low:
  - every register = RESET_VAL;
  - busy = 0;
  - data_out_a = data_out_b = 0;
  - hazard_a = hazard_b = 0.
- Reset is released synchronously to the first rising clk edge where rst_n = 1.
- Priority at each rising edge (rst_n high): clear > write/reserve.
- Clear (clear=1):
  - all registers <= RESET_VAL and busy <= 0;
  - write and reserve are ignored that cycle.
  - Reads in the same cycle return pre-clear stored contents and pre-clear busy status, with no bypass.
- Write (write=1, clear=0, writenum<DEPTH):
  - reg[writenum] <= data_in and busy[writenum] <= 0.
  - writenum>=DEPTH: no register changes.
- Reserve (reserve=1, clear=0, reservenum<DEPTH): busy[reservenum] <= 1.
  - Same edge as a write to the same register: the data is written and busy ends at 1 (reserve wins).
  - reservenum>=DEPTH is ignored.
- Read, each port independently, latency 1 cycle (rd_en_x=1 at edge N, result on data_out_x after edge N).
  - Bypass: if write=1, clear=0, and writenum==readnum_x, then data_out_x <= data_in and hazard_x <= 0.
  - Otherwise:
    - data_out_x <= reg[readnum_x];
    - hazard_x <= busy[readnum_x], sampled before the edge.
  - readnum_x>=DEPTH: data_out_x <= 0, hazard_x <= 0.
  - rd_en_x=0: data_out_x holds its previous value; hazard_x <= 0.
- Ports A and B may address the same register in the same cycle; both return identical data and hazard.
- busy is a direct register output. It reflects edge results with no additional latency.
- No combinational path from any input to any output.

Test Plan:
- Reset then read: pulse rst_n low mid-operation after writing reg3=16'h1234; release; read A=3, B=0 -> both data_out = 16'h0000, busy = 8'h00, hazards = 0.
- Dual read: write reg2=16'hBEEF, then reg5=16'h0F0F; next cycle rd_en_a=rd_en_b=1, readnum_a=2, readnum_b=5 -> one cycle later data_out_a=16'hBEEF, data_out_b=16'h0F0F.
- Bypass: reg4=16'h1111; same edge write reg4=16'h2222 and read A=4 -> data_out_a=16'h2222, reg4 reads 16'h2222 afterwards.
- Scoreboard:
  - reserve reg6 -> busy=8'h40;
  - read A=6 -> hazard_a=1;
  - write reg6=16'h00AA -> busy=8'h00;
  - read A=6 -> data_out_a=16'h00AA, hazard_a=0;
  - same-edge reserve+write on reg1=16'h7777 -> reg1=16'h7777, busy[1]=1.
- Clear:
  - regs 0..7 hold nonzero values and busy=8'hFF;
  - assert clear together with write reg0=16'h5555 and read B=0 -> data_out_b = old reg0 value;
  - afterwards all regs read 16'h0000 and busy=8'h00.
- Hold/idle: rd_en_a=0 for 3 cycles while writes change the addressed register -> data_out_a unchanged and hazard_a=0 throughout.
